l2_refill_ctrl: RTL and testbench

- Miss handler directly downstream of the L2 cache in the memory stage.
- On an L2 miss it first writes back the dirty victim line to main memory, word by word.
- It then refills the requested line word by word and returns the full line to L2.
- It drives the pipeline stall for the whole transaction. The main memory port is single-word with a request/grant plus read-valid handshake, and at most one outstanding read.

---
 rtl/mem_pkg.sv | 15 +
 rtl/l2_refill_ctrl.sv | 125 ++++++++++++
 tb/tb_l2_refill_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the L2 miss handler and its memory port.
package mem_pkg;

  typedef enum logic [2:0] {IDLE, WB, RD_REQ, RD_WAIT, DONE} refill_state_t;

  localparam int unsigned WORD_BYTES = 4;

  // Clears the byte-offset bits of a line of 'words' 32-bit words.
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int unsigned words);
    logic [63:0] mask;
    mask = 64'(words * WORD_BYTES) - 64'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/l2_refill_ctrl.sv
// L2 miss handler: writes back a dirty victim line, then refills the missed line word by word
// over a single-word request/grant + rvalid memory port with one outstanding read.
module l2_refill_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         miss_i,
  input  logic [ADDR_W-1:0]            miss_addr_i,
  input  logic                         victim_dirty_i,
  input  logic [ADDR_W-1:0]            victim_addr_i,
  input  logic [32*WORDS_PER_LINE-1:0] victim_line_i,
  output logic                         refill_valid_o,
  output logic [ADDR_W-1:0]            refill_addr_o,
  output logic [32*WORDS_PER_LINE-1:0] refill_line_o,
  output logic                         stall_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [31:0]                  mem_rdata_i
);

  localparam int unsigned CntW  = $clog2(WORDS_PER_LINE);
  localparam int unsigned LineW = 32 * WORDS_PER_LINE;
  localparam logic [CntW-1:0] LastCnt = CntW'(WORDS_PER_LINE - 1);

  refill_state_t     state_q;
  logic [CntW-1:0]   cnt_q;
  logic [ADDR_W-1:0] miss_base_q;
  logic [ADDR_W-1:0] vic_base_q;
  logic [LineW-1:0]  vic_line_q;
  logic [LineW-1:0]  line_q;
  logic [ADDR_W-1:0] word_off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      miss_base_q <= '0;
      vic_base_q  <= '0;
      vic_line_q  <= '0;
      line_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (miss_i) begin
            miss_base_q <= ADDR_W'(line_base(64'(miss_addr_i), WORDS_PER_LINE));
            vic_base_q  <= ADDR_W'(line_base(64'(victim_addr_i), WORDS_PER_LINE));
            vic_line_q  <= victim_line_i;
            cnt_q       <= '0;
            state_q     <= victim_dirty_i ? WB : RD_REQ;
          end
        end
        WB: begin
          if (mem_gnt_i) begin
            if (cnt_q == LastCnt) begin
              cnt_q   <= '0;
              state_q <= RD_REQ;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (mem_gnt_i) state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          // Read data is only ever taken here, so stray responses elsewhere fall on the floor.
          if (mem_rvalid_i) begin
            line_q[32*int'(cnt_q) +: 32] <= mem_rdata_i;
            if (cnt_q == LastCnt) begin
              cnt_q   <= '0;
              state_q <= DONE;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= RD_REQ;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign word_off = ADDR_W'(WORD_BYTES) * ADDR_W'(cnt_q);

  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    refill_valid_o = 1'b0;
    refill_addr_o  = '0;
    refill_line_o  = '0;
    unique case (state_q)
      WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = vic_base_q + word_off;
        mem_wdata_o = vic_line_q[32*int'(cnt_q) +: 32];
      end
      RD_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = miss_base_q + word_off;
      end
      DONE: begin
        refill_valid_o = 1'b1;
        refill_addr_o  = miss_base_q;
        refill_line_o  = line_q;
      end
      default: ;
    endcase
  end

  // Combinational in IDLE so the pipeline stalls in the same cycle the miss appears.
  assign stall_o = (state_q != IDLE) | miss_i;

endmodule

// File: tb/tb_l2_refill_ctrl.sv
// Scoreboard bench for l2_refill_ctrl: a memory responder and a refill monitor check the DUT
// against a line-level reference model of memory contents.
module tb_l2_refill_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 32 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_i;
  logic [AW-1:0] miss_addr_i;
  logic          victim_dirty_i;
  logic [AW-1:0] victim_addr_i;
  logic [LW-1:0] victim_line_i;
  logic          refill_valid_o;
  logic [AW-1:0] refill_addr_o;
  logic [LW-1:0] refill_line_o;
  logic          stall_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [31:0]   mem_rdata_i;

  always #5 clk = ~clk;

  l2_refill_ctrl #(.WORDS_PER_LINE(W), .ADDR_W(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .miss_i         (miss_i),
    .miss_addr_i    (miss_addr_i),
    .victim_dirty_i (victim_dirty_i),
    .victim_addr_i  (victim_addr_i),
    .victim_line_i  (victim_line_i),
    .refill_valid_o (refill_valid_o),
    .refill_addr_o  (refill_addr_o),
    .refill_line_o  (refill_line_o),
    .stall_o        (stall_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct packed {
    logic [31:0]   addr;
    logic [LW-1:0] line;
  } refill_t;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] phys_mem [logic [31:0]];
  op_t         exp_ops[$];
  refill_t     exp_refill[$];

  // Responder knobs
  int          gnt_max   = 0;
  int          rv_min    = 0;
  int          rv_max    = 0;
  int          gnt_cnt   = 0;
  bit          pend      = 1'b0;
  int          rv_cnt    = 0;
  logic [31:0] pend_data = '0;
  bit          stray_rv  = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [31:0] hold_wdata = '0;
  int          hold_left = 0;
  bit          hold_stray = 1'b0;
  int          rd_gnts   = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < W; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Line-level model: writeback goes to memory first, then the whole line is read back.
  task automatic model_miss(input logic [31:0] addr, input bit dirty, input logic [31:0] vaddr,
                            input logic [LW-1:0] vline);
    logic [31:0]   mb;
    logic [31:0]   vb;
    logic [LW-1:0] line;
    op_t           o;
    refill_t       r;
    mb = addr & ~32'(W * 4 - 1);
    vb = vaddr & ~32'(W * 4 - 1);
    if (dirty) begin
      for (int i = 0; i < W; i++) begin
        o = '{we: 1'b1, addr: vb + 32'(4 * i), wdata: vline[32*i +: 32]};
        exp_ops.push_back(o);
        ref_mem[vb + 32'(4 * i)] = vline[32*i +: 32];
      end
    end
    for (int i = 0; i < W; i++) begin
      o = '{we: 1'b0, addr: mb + 32'(4 * i), wdata: 32'h0};
      exp_ops.push_back(o);
      line[32*i +: 32] = ref_rd(mb + 32'(4 * i));
    end
    r = '{addr: mb, line: line};
    exp_refill.push_back(r);
  endtask

  // Called at a negedge; lat counts cycles from acceptance-cycle to refill_valid_o.
  task automatic do_miss(input logic [31:0] addr, input bit dirty, input logic [31:0] vaddr,
                         input logic [LW-1:0] vline, input bit keep, output int lat);
    bit done;
    model_miss(addr, dirty, vaddr, vline);
    miss_i         = 1'b1;
    miss_addr_i    = addr;
    victim_dirty_i = dirty;
    victim_addr_i  = vaddr;
    victim_line_i  = vline;
    #1 chk("stall_comb", stall_o, 1);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        miss_addr_i    = $urandom;
        victim_addr_i  = $urandom;
        victim_dirty_i = 1'($urandom);
        victim_line_i  = rand_line();
      end
      chk("stall_busy", stall_o, 1);
      if (refill_valid_o) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL refill_timeout: got no refill_valid_o expected one within 400 cycles");
    end
    if (!keep) miss_i = 1'b0;
  endtask

  // Memory responder: grants, returns reads with delay, and checks each issued op.
  initial begin
    op_t o;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
      if (!rst) begin
        if (pend) begin
          if (rv_cnt == 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = pend_data;
            pend         = 1'b0;
          end else begin
            rv_cnt--;
          end
        end else if (stray_rv) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = 32'hDEAD_BEEF;
        end
        if (mem_req_o) begin
          if (hold_left > 0 && mem_addr_o == hold_addr) begin
            hold_left--;
            if (mem_we_o) chk("hold_wdata", mem_wdata_o, hold_wdata);
            if (hold_stray && !mem_rvalid_i) begin
              mem_rvalid_i = 1'b1;
              mem_rdata_i  = 32'hBAD0_0BAD;
            end
          end else if (gnt_cnt > 0) begin
            gnt_cnt--;
          end else begin
            mem_gnt_i = 1'b1;
            if (exp_ops.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL op_unexpected: got we=%0b addr=%h expected no request",
                       mem_we_o, mem_addr_o);
            end else begin
              o = exp_ops.pop_front();
              chk("op_we", mem_we_o, o.we);
              chk("op_addr", mem_addr_o, o.addr);
              if (o.we) chk("op_wdata", mem_wdata_o, o.wdata);
            end
            if (mem_we_o) begin
              phys_mem[mem_addr_o] = mem_wdata_o;
            end else begin
              pend      = 1'b1;
              rv_cnt    = int'($urandom_range(rv_max, rv_min));
              pend_data = phys_rd(mem_addr_o);
              rd_gnts++;
            end
            gnt_cnt = int'($urandom_range(gnt_max, 0));
          end
        end
      end
    end
  end

  // Refill monitor
  initial begin
    refill_t r;
    forever begin
      @(negedge clk);
      if (!rst && refill_valid_o) begin
        if (exp_refill.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL refill_unexpected: got addr=%h expected no refill", refill_addr_o);
        end else begin
          r = exp_refill.pop_front();
          chk("refill_addr", refill_addr_o, r.addr);
          chk("refill_line", refill_line_o, r.line);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat;
    int            start;
    logic [LW-1:0] vl;
    logic [31:0]   a;
    logic [31:0]   va;
    bit            keep;

    rst = 1'b1;
    miss_i = 1'b0;
    miss_addr_i = '0;
    victim_dirty_i = 1'b0;
    victim_addr_i = '0;
    victim_line_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_refill_valid", refill_valid_o, 0);
    chk("rst_refill_addr", refill_addr_o, 0);
    chk("rst_refill_line", refill_line_o, 0);
    chk("rst_stall", stall_o, 0);
    miss_i = 1'b1;
    #1 chk("rst_stall_follows_miss", stall_o, 1);
    chk("rst_req_held", mem_req_o, 0);
    miss_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Clean miss, earliest grant/rvalid
    for (int i = 0; i < W; i++) begin
      phys_mem[32'h1230 + 32'(4 * i)] = 32'hA0 + 32'(i);
      ref_mem[32'h1230 + 32'(4 * i)]  = 32'hA0 + 32'(i);
    end
    do_miss(32'h0000_1234, 1'b0, 32'h0, '0, 1'b0, lat);
    chk("clean_latency", lat, 9);
    @(negedge clk);
    chk("stall_after_done", stall_o, 0);
    chk("refill_pulse_once", refill_valid_o, 0);

    // Dirty miss with grant withheld 5 cycles on write word 2
    for (int i = 0; i < W; i++) vl[32*i +: 32] = 32'hD000_0000 + 32'(i);
    hold_addr  = 32'h2008;
    hold_wdata = 32'hD000_0002;
    hold_left  = 5;
    do_miss(32'h0000_1234, 1'b1, 32'h0000_2004, vl, 1'b0, lat);
    chk("dirty_hold_latency", lat, 18);
    chk("hold_consumed", hold_left, 0);
    @(negedge clk);

    // Stray rvalid in IDLE, then in RD_REQ
    stray_rv = 1'b1;
    repeat (2) @(negedge clk);
    stray_rv = 1'b0;
    @(negedge clk);
    chk("stray_idle_req", mem_req_o, 0);
    chk("stray_idle_stall", stall_o, 0);
    hold_addr  = 32'h4004;
    hold_left  = 3;
    hold_stray = 1'b1;
    do_miss(32'h0000_4008, 1'b0, 32'h0, '0, 1'b0, lat);
    chk("stray_rdreq_latency", lat, 12);
    hold_stray = 1'b0;
    @(negedge clk);

    // Reset while waiting for the third read
    rv_min = 4;
    rv_max = 4;
    start  = rd_gnts;
    model_miss(32'h0000_3000, 1'b0, 32'h0, '0);
    miss_i         = 1'b1;
    miss_addr_i    = 32'h0000_3000;
    victim_dirty_i = 1'b0;
    lat = 0;
    while (rd_gnts - start < 3 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("abort_reached_third_read", 32'(rd_gnts - start), 3);
    rst    = 1'b1;
    miss_i = 1'b0;
    #1;
    chk("abort_req", mem_req_o, 0);
    chk("abort_addr", mem_addr_o, 0);
    chk("abort_stall", stall_o, 0);
    chk("abort_refill_valid", refill_valid_o, 0);
    exp_ops.delete();
    exp_refill.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_idle_req", mem_req_o, 0);
    rv_min = 0;
    rv_max = 0;
    do_miss(32'h0000_3000, 1'b0, 32'h0, '0, 1'b0, lat);
    chk("after_abort_latency", lat, 9);
    @(negedge clk);

    // Address wrap, then a back-to-back dirty miss whose victim also wraps
    do_miss(32'hFFFF_FFF8, 1'b0, 32'h0, '0, 1'b1, lat);
    chk("wrap_latency", lat, 9);
    do_miss(32'h0000_0104, 1'b1, 32'hFFFF_FFF4, rand_line(), 1'b0, lat);
    chk("b2b_latency", lat, 14);
    @(negedge clk);

    // Randomised traffic over a small pool of lines so victims and misses collide
    gnt_max = 3;
    rv_max  = 3;
    keep    = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!keep) repeat ($urandom_range(2, 0)) @(negedge clk);
      a    = 32'h0001_0000 + 32'($urandom_range(7, 0) << 4) + 32'($urandom_range(15, 0));
      va   = 32'h0001_0000 + 32'($urandom_range(7, 0) << 4) + 32'($urandom_range(15, 0));
      keep = (n != 39) && ($urandom_range(3, 0) == 0);
      do_miss(a, 1'($urandom), va, rand_line(), keep, lat);
    end
    miss_i = 1'b0;

    repeat (20) @(negedge clk);
    chk("ops_drained", 32'(exp_ops.size()), 0);
    chk("refills_drained", 32'(exp_refill.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
